// File: rtl/instr_decode_queue_pkg.sv
// Shared decode definitions for the instruction decode queue.
// Contents: class bit indices (one-hot position in the class vector),
// opcode/funct encodings, sub-op codes, and a decode-result struct with
// a constructor helper.
package instr_decode_pkg;

   localparam int unsigned CLASS_W = 10;
   localparam int unsigned SUBOP_W = 4;

   // Bit positions within the one-hot class vector
   localparam int unsigned CLS_RRCAL = 0;
   localparam int unsigned CLS_RICAL = 1;
   localparam int unsigned CLS_LM    = 2;
   localparam int unsigned CLS_SM    = 3;
   localparam int unsigned CLS_MD    = 4;
   localparam int unsigned CLS_B     = 5;
   localparam int unsigned CLS_J     = 6;
   localparam int unsigned CLS_NOP   = 7;
   localparam int unsigned CLS_EXT   = 8;
   localparam int unsigned CLS_ILL   = 9;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LB      = 6'b100000;
   localparam logic [5:0] OP_LH      = 6'b100001;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SB      = 6'b101000;
   localparam logic [5:0] OP_SH      = 6'b101001;
   localparam logic [5:0] OP_SW      = 6'b101011;
   localparam logic [5:0] OP_EXT     = 6'b111111;

   // Function codes (instr[5:0]) under OP_SPECIAL
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   // Sub-op codes (index within class)
   localparam logic [SUBOP_W-1:0] SUB_NONE  = 4'd0;
   localparam logic [SUBOP_W-1:0] SUB_ADD   = 4'd0;
   localparam logic [SUBOP_W-1:0] SUB_SUB   = 4'd1;
   localparam logic [SUBOP_W-1:0] SUB_AND   = 4'd2;
   localparam logic [SUBOP_W-1:0] SUB_OR    = 4'd3;
   localparam logic [SUBOP_W-1:0] SUB_SLT   = 4'd4;
   localparam logic [SUBOP_W-1:0] SUB_SLTU  = 4'd5;
   localparam logic [SUBOP_W-1:0] SUB_ADDI  = 4'd0;
   localparam logic [SUBOP_W-1:0] SUB_ANDI  = 4'd1;
   localparam logic [SUBOP_W-1:0] SUB_ORI   = 4'd2;
   localparam logic [SUBOP_W-1:0] SUB_LUI   = 4'd3;
   localparam logic [SUBOP_W-1:0] SUB_BYTE  = 4'd0;
   localparam logic [SUBOP_W-1:0] SUB_HALF  = 4'd1;
   localparam logic [SUBOP_W-1:0] SUB_WORD  = 4'd2;
   localparam logic [SUBOP_W-1:0] SUB_MULT  = 4'd0;
   localparam logic [SUBOP_W-1:0] SUB_MULTU = 4'd1;
   localparam logic [SUBOP_W-1:0] SUB_DIV   = 4'd2;
   localparam logic [SUBOP_W-1:0] SUB_DIVU  = 4'd3;
   localparam logic [SUBOP_W-1:0] SUB_MFHI  = 4'd4;
   localparam logic [SUBOP_W-1:0] SUB_MFLO  = 4'd5;
   localparam logic [SUBOP_W-1:0] SUB_MTHI  = 4'd6;
   localparam logic [SUBOP_W-1:0] SUB_MTLO  = 4'd7;
   localparam logic [SUBOP_W-1:0] SUB_BEQ   = 4'd0;
   localparam logic [SUBOP_W-1:0] SUB_BNE   = 4'd1;
   localparam logic [SUBOP_W-1:0] SUB_JAL   = 4'd0;
   localparam logic [SUBOP_W-1:0] SUB_JR    = 4'd1;

   typedef struct packed {
      logic [CLASS_W-1:0] cls;
      logic [SUBOP_W-1:0] subop;
   } decode_t;

   function automatic decode_t mk_dec(input int unsigned cls_idx,
                                      input logic [SUBOP_W-1:0] sub);
      decode_t d;
      d.cls          = '0;
      d.cls[cls_idx] = 1'b1;
      d.subop        = sub;
      return d;
   endfunction

endpackage

// File: rtl/instr_decode_queue_classifier.sv
// Purely combinational instruction classifier.
// Ports: instr_i (32-bit raw word) -> class_o (one-hot CLASS_W), subop_o.
// Build option: DECODE_EXT_OP_EN maps opcode 111111 to class EXT; when
// undefined that opcode falls through to ILL.
module instr_classifier
   import instr_decode_pkg::*;
(
   input  logic [31:0]        instr_i,
   output logic [CLASS_W-1:0] class_o,
   output logic [SUBOP_W-1:0] subop_o
);

   logic [5:0] op;
   logic [5:0] funct;
   decode_t    dec;

   assign op    = instr_i[31:26];
   assign funct = instr_i[5:0];

   always_comb begin
      dec = mk_dec(CLS_ILL, SUB_NONE);
      // All-zero word is the canonical NOP and wins over the SPECIAL decode
      if (instr_i == '0) begin
         dec = mk_dec(CLS_NOP, SUB_NONE);
      end else begin
         case (op)
            OP_SPECIAL: begin
               case (funct)
                  FN_ADD:   dec = mk_dec(CLS_RRCAL, SUB_ADD);
                  FN_SUB:   dec = mk_dec(CLS_RRCAL, SUB_SUB);
                  FN_AND:   dec = mk_dec(CLS_RRCAL, SUB_AND);
                  FN_OR:    dec = mk_dec(CLS_RRCAL, SUB_OR);
                  FN_SLT:   dec = mk_dec(CLS_RRCAL, SUB_SLT);
                  FN_SLTU:  dec = mk_dec(CLS_RRCAL, SUB_SLTU);
                  FN_MULT:  dec = mk_dec(CLS_MD, SUB_MULT);
                  FN_MULTU: dec = mk_dec(CLS_MD, SUB_MULTU);
                  FN_DIV:   dec = mk_dec(CLS_MD, SUB_DIV);
                  FN_DIVU:  dec = mk_dec(CLS_MD, SUB_DIVU);
                  FN_MFHI:  dec = mk_dec(CLS_MD, SUB_MFHI);
                  FN_MFLO:  dec = mk_dec(CLS_MD, SUB_MFLO);
                  FN_MTHI:  dec = mk_dec(CLS_MD, SUB_MTHI);
                  FN_MTLO:  dec = mk_dec(CLS_MD, SUB_MTLO);
                  FN_JR:    dec = mk_dec(CLS_J, SUB_JR);
                  default:  ;
               endcase
            end
            OP_ADDI: dec = mk_dec(CLS_RICAL, SUB_ADDI);
            OP_ANDI: dec = mk_dec(CLS_RICAL, SUB_ANDI);
            OP_ORI:  dec = mk_dec(CLS_RICAL, SUB_ORI);
            OP_LUI:  dec = mk_dec(CLS_RICAL, SUB_LUI);
            OP_LB:   dec = mk_dec(CLS_LM, SUB_BYTE);
            OP_LH:   dec = mk_dec(CLS_LM, SUB_HALF);
            OP_LW:   dec = mk_dec(CLS_LM, SUB_WORD);
            OP_SB:   dec = mk_dec(CLS_SM, SUB_BYTE);
            OP_SH:   dec = mk_dec(CLS_SM, SUB_HALF);
            OP_SW:   dec = mk_dec(CLS_SM, SUB_WORD);
            OP_BEQ:  dec = mk_dec(CLS_B, SUB_BEQ);
            OP_BNE:  dec = mk_dec(CLS_B, SUB_BNE);
            OP_JAL:  dec = mk_dec(CLS_J, SUB_JAL);
`ifdef DECODE_EXT_OP_EN
            OP_EXT:  dec = mk_dec(CLS_EXT, SUB_NONE);
`endif
            default: ;
         endcase
      end
   end

   assign class_o = dec.cls;
   assign subop_o = dec.subop;

endmodule

// File: rtl/instr_decode_queue.sv
// Registered decode front-end: classifies fetched instructions at enqueue
// and buffers {instr, pc, class, subop} in a DEPTH-entry FIFO for the D stage.
// Ports: clk, reset (async, active-high), flush;
//   in_valid/in_ready/in_instr/in_pc    - fetch side
//   out_valid/out_ready/out_instr/out_pc/out_class/out_subop - decode side
//   illegal_cnt - saturating count of ILL instructions enqueued.
// Build option: DECODE_EXT_OP_EN (see instr_classifier).
module instr_decode_queue
   import instr_decode_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PC_W  = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [CLASS_W-1:0] out_class,
   output logic [SUBOP_W-1:0] out_subop,
   output logic [CNT_W-1:0]   illegal_cnt
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]        count_q, count_d;
   logic [CNT_W-1:0]   ill_cnt_q, ill_cnt_d;

   logic [31:0]        instr_mem [DEPTH];
   logic [PC_W-1:0]    pc_mem    [DEPTH];
   logic [CLASS_W-1:0] class_mem [DEPTH];
   logic [SUBOP_W-1:0] subop_mem [DEPTH];

   logic [CLASS_W-1:0] in_class;
   logic [SUBOP_W-1:0] in_subop;
   logic               push, pop, wr_en;

   instr_classifier u_classifier (
      .instr_i (in_instr),
      .class_o (in_class),
      .subop_o (in_subop)
   );

   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   // Flush discards the same-cycle push, so storage is not written either
   assign wr_en     = push & ~flush;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ill_cnt_d = ill_cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: ;
         endcase
         if (push && in_class[CLS_ILL] && (ill_cnt_q != '1))
            ill_cnt_d = ill_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ill_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ill_cnt_q <= ill_cnt_d;
      end
   end

   // Storage needs no reset: head outputs are masked while the queue is empty
   always_ff @(posedge clk) begin
      if (wr_en) begin
         instr_mem[wr_ptr_q] <= in_instr;
         pc_mem[wr_ptr_q]    <= in_pc;
         class_mem[wr_ptr_q] <= in_class;
         subop_mem[wr_ptr_q] <= in_subop;
      end
   end

   assign out_instr   = out_valid ? instr_mem[rd_ptr_q] : '0;
   assign out_pc      = out_valid ? pc_mem[rd_ptr_q]    : '0;
   assign out_class   = out_valid ? class_mem[rd_ptr_q] : '0;
   assign out_subop   = out_valid ? subop_mem[rd_ptr_q] : '0;
   assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: the driver pushes the expected
// head contents when an enqueue is accepted; a monitor pops and compares
// on every consumed head. Honours DECODE_EXT_OP_EN for the 0xFC000000 case.
module tb_instr_decode_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PC_W  = 32;
   localparam int unsigned CNT_W = 8;

   localparam logic [9:0] C_RR  = 10'h001;
   localparam logic [9:0] C_RI  = 10'h002;
   localparam logic [9:0] C_LM  = 10'h004;
   localparam logic [9:0] C_SM  = 10'h008;
   localparam logic [9:0] C_MD  = 10'h010;
   localparam logic [9:0] C_B   = 10'h020;
   localparam logic [9:0] C_J   = 10'h040;
   localparam logic [9:0] C_NOP = 10'h080;
   localparam logic [9:0] C_ILL = 10'h200;
`ifdef DECODE_EXT_OP_EN
   localparam logic [9:0] C_FC  = 10'h100;
`else
   localparam logic [9:0] C_FC  = 10'h200;
`endif

   logic             clk = 1'b0;
   logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]      in_instr, out_instr;
   logic [PC_W-1:0]  in_pc, out_pc;
   logic [9:0]       out_class;
   logic [3:0]       out_subop;
   logic [CNT_W-1:0] illegal_cnt;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [9:0]  cls;
      logic [3:0]  sub;
   } exp_t;

   exp_t             exp_q[$];
   exp_t             mon_e;
   int unsigned      n_vec = 0;
   int unsigned      n_bad = 0;
   logic [CNT_W-1:0] ill_exp;
   logic [31:0]      pc_ctr;

   instr_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_class   (out_class),
      .out_subop   (out_subop),
      .illegal_cnt (illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: a head consumed at the coming edge is compared here
   initial forever begin
      @(negedge clk);
      if (!reset && !flush) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL pop_unexpected: got instr 0x%0h, expected no entry", out_instr);
            end else begin
               mon_e = exp_q.pop_front();
               check("out_instr", 64'(out_instr), 64'(mon_e.instr));
               check("out_pc",    64'(out_pc),    64'(mon_e.pc));
               check("out_class", 64'(out_class), 64'(mon_e.cls));
               check("out_subop", 64'(out_subop), 64'(mon_e.sub));
            end
         end else if (!out_valid) begin
            check("empty_class", 64'(out_class), 64'(0));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] instr, input logic [9:0] cls, input logic [3:0] sub);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc_ctr;
      if (in_ready) begin
         exp_q.push_back('{instr, pc_ctr, cls, sub});
         if (cls == C_ILL && ill_exp != '1) ill_exp++;
      end
      pc_ctr += 32'd4;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 40 && out_valid; i++) cyc();
      check("drain_done", 64'(out_valid), 64'(0));
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0; ill_exp = '0; pc_ctr = 32'h0040_0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid),   64'(0));
      check("rst_in_ready",  64'(in_ready),    64'(1));
      check("rst_class",     64'(out_class),   64'(0));
      check("rst_instr",     64'(out_instr),   64'(0));
      check("rst_ill_cnt",   64'(illegal_cnt), 64'(0));
      reset = 1'b0;
      cyc();

      // First push visible one cycle later
      push(32'h0085_1020, C_RR, 4'd0);
      check("lat_valid", 64'(out_valid), 64'(1));
      check("lat_class", 64'(out_class), 64'(10'h001));
      check("lat_pc",    64'(out_pc),    64'(32'h0040_0000));
      push(32'h0000_0000, C_NOP, 4'd0);
      push(32'h8C88_0004, C_LM,  4'd2);
      out_ready = 1'b1;
      wait_empty();
      out_ready = 1'b0;

      // Fill to DEPTH, 5th blocked, drain in order
      for (int i = 0; i < 4; i++) begin
         push(32'h2084_0000 | 32'(i), C_RI, 4'd0);
         check("fill_in_ready", 64'(in_ready), (i < 3) ? 64'(1) : 64'(0));
      end
      push(32'h0085_1022, C_RR, 4'd1);
      check("full_blocked", 64'(in_ready), 64'(0));
      out_ready = 1'b1;
      wait_empty();
      out_ready = 1'b0;

      // Two held, then push+pop each cycle across pointer wrap
      push(32'h0085_1022, C_RR, 4'd1);
      push(32'h0085_102A, C_RR, 4'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push(32'h0085_0024 | (32'(i) << 11), C_RR, 4'd2);
         check("pp_in_ready", 64'(in_ready), 64'(1));
      end
      check("pp_left2", 64'(out_valid), 64'(1));
      cyc();
      check("pp_left1", 64'(out_valid), 64'(1));
      cyc();
      check("pp_left0", 64'(out_valid), 64'(0));
      out_ready = 1'b0;

      // Decode table, streamed
      out_ready = 1'b1;
      push(32'h0085_1024, C_RR, 4'd2);
      push(32'h0085_1025, C_RR, 4'd3);
      push(32'h0085_102B, C_RR, 4'd5);
      push(32'h3084_00FF, C_RI, 4'd1);
      push(32'h3484_00FF, C_RI, 4'd2);
      push(32'h3C04_1234, C_RI, 4'd3);
      push(32'h8088_0000, C_LM, 4'd0);
      push(32'h8488_0002, C_LM, 4'd1);
      push(32'hA088_0000, C_SM, 4'd0);
      push(32'hA488_0002, C_SM, 4'd1);
      push(32'hAC88_0004, C_SM, 4'd2);
      push(32'h0085_0018, C_MD, 4'd0);
      push(32'h0085_0019, C_MD, 4'd1);
      push(32'h0085_001A, C_MD, 4'd2);
      push(32'h0085_001B, C_MD, 4'd3);
      push(32'h0000_1010, C_MD, 4'd4);
      push(32'h0000_1012, C_MD, 4'd5);
      push(32'h0080_0011, C_MD, 4'd6);
      push(32'h0080_0013, C_MD, 4'd7);
      push(32'h1085_0003, C_B,  4'd0);
      push(32'h1485_0003, C_B,  4'd1);
      push(32'h0C00_0010, C_J,  4'd0);
      push(32'h03E0_0008, C_J,  4'd1);
      push(32'h0000_0001, C_ILL, 4'd0);
      push(32'h0400_0000, C_ILL, 4'd0);
      wait_empty();
      check("tbl_ill_cnt", 64'(illegal_cnt), 64'(ill_exp));
      check("tbl_ill_cnt2", 64'(illegal_cnt), 64'(2));
      out_ready = 1'b0;

      // Asynchronous reset mid-operation
      push(32'h0085_1020, C_RR, 4'd0);
      push(32'h0085_1022, C_RR, 4'd1);
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid),   64'(0));
      check("arst_in_ready",  64'(in_ready),    64'(1));
      check("arst_ill_cnt",   64'(illegal_cnt), 64'(0));
      exp_q.delete();
      ill_exp = '0;
      cyc();
      reset = 1'b0;
      cyc();

      // Extension opcode
      push(32'hFC00_0000, C_FC, 4'd0);
      check("ext_class", 64'(out_class), 64'(C_FC));
`ifdef DECODE_EXT_OP_EN
      check("ext_ill_cnt", 64'(illegal_cnt), 64'(0));
`else
      check("ext_ill_cnt", 64'(illegal_cnt), 64'(1));
`endif
      out_ready = 1'b1;
      wait_empty();
      out_ready = 1'b0;

      // Flush with concurrent ILL push and pop: all discarded
      push(32'h0085_1020, C_RR, 4'd0);
      push(32'h0085_1022, C_RR, 4'd1);
      push(32'h0085_1024, C_RR, 4'd2);
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0400_0000; out_ready = 1'b1;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      check("flush_out_valid", 64'(out_valid),   64'(0));
      check("flush_in_ready",  64'(in_ready),    64'(1));
      check("flush_ill_cnt",   64'(illegal_cnt), 64'(ill_exp));
      push(32'h0085_102B, C_RR, 4'd5);
      wait_empty();

      // Saturation of the illegal counter
      for (int i = 0; i < 300; i++) push(32'h0400_0000 | 32'(i), C_ILL, 4'd0);
      wait_empty();
      check("sat_ill_cnt", 64'(illegal_cnt), 64'(8'hFF));
      check("sat_model",   64'(illegal_cnt), 64'(ill_exp));
      check("sb_empty",    64'(exp_q.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
